lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; data width fixed at 32, DMEM word-addressed by addr[9:2] (256 words).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core requests a load/store this cycle.
REQ-005 req_ready  output  1  controller can accept a request (high only in IDLE).
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address of access.
REQ-009 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 resp_valid  output  1  one-cycle pulse: access complete.
REQ-011 rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-012 err  output  1  valid with resp_valid: misaligned or illegal funct3.
REQ-013 MemRead  output  1  read strobe to data memory.
REQ-014 MemWrite  output  1  write strobe to data memory (written at next posedge).
REQ-015 mem_addr  output  32  {addr_q[31:2],2'b00}, word-aligned.
REQ-016 mem_wdata  output  32  merged word to write.
REQ-017 mem_rdata  input  32  word read from memory, combinational while MemRead=1.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR, RESP; MemRead=1 only in RD, MemWrite=1 only in WR, decoded from state (no extra cycle).
REQ-019 Request accepted on posedge when req_valid & req_ready; req_we, funct3, addr, wdata SHALL be captured into registers at that edge.
REQ-020 Error check at accept: H misaligned if addr[0]=1; W misaligned if addr[1:0]!=0; funct3 011/110/111, or 100/101 with req_we=1, illegal.
REQ-021 Error request: IDLE->RESP; no MemRead/MemWrite asserted; resp_valid with err=1, rdata=0.
REQ-022 Load: IDLE->RD->RESP; mem_rdata captured at RD exit edge; resp_valid 2 cycles after accept edge.
REQ-023 Load extraction little-endian: byte = word[8*addr[1:0]+:8], half = word[16*addr[1]+:16]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-024 SW: IDLE->WR->RESP; mem_wdata=wdata; resp_valid 2 cycles after accept.
REQ-025 SB/SH: IDLE->RD->WR->RESP read-modify-write; old word captured in RD, only the addressed byte/half lanes replaced in WR; resp_valid 3 cycles after accept.
REQ-026 RESP lasts exactly one cycle then IDLE; req_ready=1 in IDLE so a new request can be accepted the cycle after RESP.
REQ-027 Requests while not IDLE SHALL be ignored (req_ready=0); core holds req_valid until accepted.
REQ-028 rdata/err SHALL hold their value until the next RESP; meaningful only while resp_valid=1.
REQ-029 Each accepted store SHALL assert MemWrite for exactly one cycle; each load/RMW asserts MemRead exactly one cycle.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, all captured registers, rdata, err, resp_valid=0, MemRead=MemWrite=0, mem_addr=mem_wdata=0, req_ready=1 after release.
REQ-031 Reset during RD or WR SHALL abort the access; MemWrite drops immediately so no partial write occurs at the next edge; no resp_valid for the aborted request.

Verification
REQ-032 Mem[0x10]=0x8899AABB; LB addr 0x11 -> one MemRead, resp_valid at accept+2, rdata=0xFFFFFFAA, err=0.
REQ-033 Same word; LHU addr 0x12 -> rdata=0x00008899; LW addr 0x10 -> rdata=0x8899AABB.
REQ-034 SB addr 0x13 wdata 0x12345655 -> MemRead 1 cycle, MemWrite 1 cycle with mem_wdata=0x5599AABB, resp_valid at accept+3, rdata=0.
REQ-035 LW addr 0x06 and SH addr 0x11 -> err=1, resp_valid at accept+1, MemRead/MemWrite never asserted, memory unchanged.
REQ-036 SW addr 0x20 wdata 0xDEADBEEF with rst pulsed while in WR -> MemWrite falls with rst, Mem[0x20] unchanged, no resp_valid, req_ready=1 after release.
REQ-037 req_valid held high for two back-to-back LW -> second accepted on cycle after first RESP; req_ready=0 throughout first access.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences single-word DMEM accesses for RV32I
// loads and stores, including read-modify-write for byte/halfword stores.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;    // old memory word for read-modify-write
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Misaligned or illegal width/sign code for the requested direction.
    function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lo[0];
            3'b010:  bad = (lo != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane extraction with sign/zero extension.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'b0, b};
            3'b101:  res = {16'b0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // State and captured request registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            word_q  <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; rdata/err are only updated on the edge entering StResp.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (access_bad(req_we, funct3, addr[1:0])) begin
                        state_d = StResp;
                        rdata_d = 32'b0;
                        err_d   = 1'b1;
                    end else if (req_we && funct3 == 3'b010) begin
                        state_d = StWr;
                    end else begin
                        // Loads and sub-word stores both need the old word.
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                word_d = mem_rdata;
                if (we_q) begin
                    state_d = StWr;
                end else begin
                    state_d = StResp;
                    rdata_d = load_ext(f3_q, addr_q[1:0], mem_rdata);
                    err_d   = 1'b0;
                end
            end
            StWr: begin
                state_d = StResp;
                rdata_d = 32'b0;
                err_d   = 1'b0;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Store data merge: replace only the addressed lanes of the old word.
    always_comb begin
        mem_wdata = word_q;
        case (f3_q[1:0])
            2'b00: begin
                case (addr_q[1:0])
                    2'b00:   mem_wdata[7:0]   = wdata_q[7:0];
                    2'b01:   mem_wdata[15:8]  = wdata_q[7:0];
                    2'b10:   mem_wdata[23:16] = wdata_q[7:0];
                    default: mem_wdata[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) mem_wdata[31:16] = wdata_q[15:0];
                else           mem_wdata[15:0]  = wdata_q[15:0];
            end
            default: mem_wdata = wdata_q;
        endcase
    end

    // Strobes and handshakes decoded straight from state.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        MemRead    = (state_q == StRd);
        MemWrite   = (state_q == StWr);
        mem_addr   = {addr_q[31:2], 2'b00};
        rdata      = rdata_q;
        err        = err_q;
    end

endmodule
